down_counter_timer: RTL and testbench
=====================================

// Module: down_counter_timer
// PURPOSE
//   Loadable down-counter/timer, the count-down counterpart of the team's up-counter.
//   Loads a start value, decrements on each enabled clock, and flags terminal count
//   with a one-cycle pulse. Optional auto-reload gives periodic tc pulses.
//   Used as a programmable delay/period generator next to the up-counter datapath.
// PARAMETERS
//   w   8      counter/data width in bits
//   vi  8'hff  value of q after rst or clr (w bits wide)
// PORTS
//   clk      in   1  clock; all state changes on posedge clk
//   rst      in   1  reset, synchronous, active-high
//   clr      in   1  synchronous clear: q<=vi, FSM to IDLE
//   ld       in   1  load strobe: q<=d, rl<=d, start run
//   d        in   w  load value
//   c_down   in   1  count enable (decrement when RUN)
//   auto_rl  in   1  1: reload rl after zero; 0: stop in DONE
//   q        out  w  current count (registered)
//   zero     out  1  combinational, (q == 0)
//   tc       out  1  terminal-count pulse (registered, 1 cycle)
//   busy     out  1  1 while FSM in RUN
// BEHAVIOUR
//   Reset (rst=1 at posedge): q=vi, rl=vi, state=IDLE, tc=0, busy=0.
//   Per-edge priority: rst > clr > ld > c_down. Lower-priority inputs are ignored that cycle.
//   Internal reload reg rl[w-1:0] is written only by ld (and rst).
//   FSM states:
//   - IDLE: q holds, c_down ignored; ld -> RUN (d!=0) or DONE (d==0).
//   - RUN : c_down=0 -> q holds. c_down=1:
//     - q>1  -> q<=q-1.
//     - q==1 -> q<=0, tc<=1; if auto_rl=0 go DONE, else stay RUN.
//     - q==0 (only reachable with auto_rl=1) -> q<=rl, stay RUN.
//     - Auto-reload period = rl+1 enabled cycles; tc fires once per period.
//     - auto_rl is sampled at the edge where q goes 1->0.
//   - DONE: q holds 0, c_down ignored; ld or clr leaves.
//   Load detail:
//   - ld with d==0: q=0, state=DONE, tc=0 (no pulse).
//   - ld in RUN restarts the count immediately.
//   tc:
//   - tc=1 exactly in the cycle after the edge where q became 0 by decrement.
//   - tc is 0 on any cycle following rst, clr or ld.
//   - tc never stays high two consecutive cycles (requires rl>=1, guaranteed).
//   Arithmetic: modulo 2^w, but decrement below 0 never occurs.
//   busy = (state==RUN), registered state decode; zero is combinational from q.
//   Reset or clr mid-run aborts the run; no tc is generated.
// TESTING
//   1 rst=1 two cycles, then c_down=1 for 3 cycles
//     -> q=8'hff, busy=0, zero=0, tc=0 throughout (IDLE ignores c_down).
//   2 ld d=3, then c_down=1 continuously, auto_rl=0
//     -> q: 3,2,1,0; tc=1 only in the q==0 cycle; busy drops to 0; q stays 0 for 5 more cycles.
//   3 auto_rl=1, ld d=2, c_down=1 for 9 cycles
//     -> q: 2,1,0,2,1,0,2,1,0; tc pulses every 3rd cycle, aligned with q==0; busy stays 1.
//   4 ld d=5, c_down pattern 1,0,0,1,1
//     -> q: 5,4,4,4,3,2 (holds while c_down=0).
//   5 ld d=4, two decrements, then clr=1 and ld=1 same cycle (d=9)
//     -> q=vi, IDLE, busy=0, tc=0; ld ignored.
//     Repeat with rst=1 instead: same result.
//   6 ld d=0
//     -> q=0, zero=1, busy=0, tc=0 on all following cycles; c_down has no effect.

Source files
------------

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
//
// Loadable down-counter/timer. A load strobe captures a start value into both
// the count register and an internal reload register and starts a run. Each
// enabled clock in RUN decrements the count. When the count reaches zero by
// decrement, a registered one-cycle terminal-count pulse (tc) is raised. With
// auto-reload set, the counter refills from the reload register on the next
// enabled clock, which gives periodic tc pulses every rl+1 enabled cycles.
// Without auto-reload, the counter parks in DONE at zero.
//
// Parameters
//   w          counter/data width in bits
//   vi         value of q after rst or clr
//
// Ports
//   clk        clock; all state changes on posedge clk
//   rst        synchronous active-high reset
//   clr        synchronous clear: q <= vi, FSM to IDLE
//   ld         load strobe: q <= d, rl <= d, start run (or DONE if d == 0)
//   d          load value
//   c_down     count enable (acts only in RUN)
//   auto_rl    1: reload from rl after zero; 0: stop in DONE
//   q          current count (registered)
//   zero       combinational (q == 0)
//   tc         terminal-count pulse (registered, one cycle)
//   busy       1 while the FSM is in RUN
//   dbg_state  current FSM state encoding (IDLE=0, RUN=1, DONE=2)
//
// Per-edge priority: rst > clr > ld > c_down. When an input wins at an edge,
// the lower-priority inputs are ignored at that edge.
// -----------------------------------------------------------------------------
module down_counter_timer #(
  parameter int unsigned   w  = 8,
  parameter logic [w-1:0]  vi = 8'hff
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [w-1:0] d,
  input  logic         c_down,
  input  logic         auto_rl,
  output logic [w-1:0] q,
  output logic         zero,
  output logic         tc,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [w-1:0] ONE  = {{(w-1){1'b0}}, 1'b1};
  localparam logic [w-1:0] NULL = '0;

  state_t       state;
  state_t       state_n;
  logic [w-1:0] q_n;
  logic [w-1:0] rl;
  logic [w-1:0] rl_n;
  logic         tc_n;

  // State, count, reload and tc registers. Reset has top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= vi;
      rl    <= vi;
      tc    <= 1'b0;
    end else begin
      state <= state_n;
      q     <= q_n;
      rl    <= rl_n;
      tc    <= tc_n;
    end
  end

  // Next-state and next-datapath logic. tc_n defaults to 0, so that tc is
  // only ever high for the single cycle after a decrement reaches zero.
  always_comb begin
    state_n = state;
    q_n     = q;
    rl_n    = rl;
    tc_n    = 1'b0;

    if (clr) begin
      state_n = IDLE;
      q_n     = vi;
    end else if (ld) begin
      q_n     = d;
      rl_n    = d;
      // A zero load has nothing to count: park in DONE with no pulse.
      state_n = (d == NULL) ? DONE : RUN;
    end else begin
      unique case (state)
        IDLE: begin
          // Count enable is ignored until a load starts a run.
        end
        RUN: begin
          if (c_down) begin
            if (q > ONE) begin
              q_n = q - ONE;
            end else if (q == ONE) begin
              q_n  = NULL;
              tc_n = 1'b1;
              // auto_rl is sampled at this 1->0 edge only.
              state_n = auto_rl ? RUN : DONE;
            end else begin
              // q == 0 in RUN happens only under auto-reload; refill.
              q_n = rl;
            end
          end
        end
        DONE: begin
          // Holds at zero; only ld or clr leave this state.
        end
        default: begin
          state_n = IDLE;
          q_n     = vi;
        end
      endcase
    end
  end

  assign zero      = (q == NULL);
  assign busy      = (state == RUN);
  assign dbg_state = state;

endmodule

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
//
// Each vector holds the inputs applied at one posedge, plus the q/zero/tc/busy
// values expected just after that edge. The main table walks the directed
// scenarios in order, and hand-written sequences cover the priority and
// auto-reload corner cases.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

  localparam int W = 8;

  // Clock / reset / DUT signals
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         ld  = 1'b0;
  logic [W-1:0] d   = '0;
  logic         c_down  = 1'b0;
  logic         auto_rl = 1'b0;
  logic [W-1:0] q;
  logic         zero;
  logic         tc;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  down_counter_timer #(.w(W), .vi(8'hff)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .ld        (ld),
    .d         (d),
    .c_down    (c_down),
    .auto_rl   (auto_rl),
    .q         (q),
    .zero      (zero),
    .tc        (tc),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic         rst;
    logic         clr;
    logic         ld;
    logic [W-1:0] d;
    logic         c_down;
    logic         auto_rl;
    logic [W-1:0] exp_q;
    logic         exp_zero;
    logic         exp_tc;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  function automatic vec_t mk(logic r, logic c, logic l, logic [W-1:0] dv,
                              logic cd, logic ar, logic [W-1:0] eq,
                              logic ez, logic et, logic eb);
    vec_t v;
    v.rst = r;  v.clr = c;  v.ld = l;  v.d = dv;
    v.c_down = cd;  v.auto_rl = ar;
    v.exp_q = eq;  v.exp_zero = ez;  v.exp_tc = et;  v.exp_busy = eb;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_q(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Driver: apply one vector at the next posedge, then sample 1 time unit later.
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst;  clr = v.clr;  ld = v.ld;  d = v.d;
    c_down = v.c_down;  auto_rl = v.auto_rl;
    @(posedge clk);
    #1;
    check_q  ({tag, ".q"},    q,    v.exp_q);
    check_bit({tag, ".zero"}, zero, v.exp_zero);
    check_bit({tag, ".tc"},   tc,   v.exp_tc);
    check_bit({tag, ".busy"}, busy, v.exp_busy);
  endtask

  initial begin
    // ---------------- main table ----------------
    // 1: reset two cycles, then IDLE ignores c_down
    vecs.push_back(mk(1,0,0,0,  0,0, 8'hff,0,0,0));
    vecs.push_back(mk(1,0,0,0,  0,0, 8'hff,0,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,0, 8'hff,0,0,0));
    // 2: load 3, count to 0, stop in DONE
    vecs.push_back(mk(0,0,1,3,  0,0, 3,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 2,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 1,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 0,1,1,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0, 1,0, 0,1,0,0));
    // 3: auto-reload period 3 with d=2
    vecs.push_back(mk(0,0,1,2,  0,1, 2,0,0,1));
    for (int k = 0; k < 3; k++) begin
      vecs.push_back(mk(0,0,0,0, 1,1, 1,0,0,1));
      vecs.push_back(mk(0,0,0,0, 1,1, 0,1,1,1));
      vecs.push_back(mk(0,0,0,0, 1,1, 2,0,0,1));
    end
    // 4: load 5, enable pattern 1,0,0,1,1
    vecs.push_back(mk(0,0,1,5,  0,0, 5,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 4,0,0,1));
    vecs.push_back(mk(0,0,0,0,  0,0, 4,0,0,1));
    vecs.push_back(mk(0,0,0,0,  0,0, 4,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 3,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 2,0,0,1));
    // 5a: clr beats ld mid-run
    vecs.push_back(mk(0,0,1,4,  0,0, 4,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 3,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 2,0,0,1));
    vecs.push_back(mk(0,1,1,9,  1,0, 8'hff,0,0,0));
    vecs.push_back(mk(0,0,0,0,  1,0, 8'hff,0,0,0));
    // 5b: rst beats ld mid-run
    vecs.push_back(mk(0,0,1,4,  0,0, 4,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 3,0,0,1));
    vecs.push_back(mk(0,0,0,0,  1,0, 2,0,0,1));
    vecs.push_back(mk(1,0,1,9,  1,0, 8'hff,0,0,0));
    vecs.push_back(mk(0,0,0,0,  1,0, 8'hff,0,0,0));
    // 6: zero load goes straight to DONE, no pulse
    vecs.push_back(mk(0,0,1,0,  0,0, 0,1,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,1, 0,1,0,0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // ---------------- hand-written corner sequences ----------------
    // auto_rl taken from the 1->0 edge: dropping it there stops in DONE
    apply(mk(0,0,1,2, 0,1, 2,0,0,1), "ar_drop.ld");
    apply(mk(0,0,0,0, 1,1, 1,0,0,1), "ar_drop.dec");
    apply(mk(0,0,0,0, 1,0, 0,1,1,0), "ar_drop.zero");
    apply(mk(0,0,0,0, 1,1, 0,1,0,0), "ar_drop.hold");

    // clr at q==1 with c_down: aborts, no tc
    apply(mk(0,0,1,1, 0,0, 1,0,0,1), "clr_tc.ld");
    apply(mk(0,1,0,0, 1,0, 8'hff,0,0,0), "clr_tc.clr");
    apply(mk(0,0,0,0, 1,0, 8'hff,0,0,0), "clr_tc.after");

    // ld at q==1 in RUN restarts the count, no tc
    apply(mk(0,0,1,1, 0,0, 1,0,0,1), "ld_restart.ld1");
    apply(mk(0,0,1,7, 1,0, 7,0,0,1), "ld_restart.ld7");
    apply(mk(0,0,0,0, 1,0, 6,0,0,1), "ld_restart.dec");

    // shortest auto-reload period (rl=1): tc on alternate cycles
    apply(mk(0,0,1,1, 0,1, 1,0,0,1), "rl1.ld");
    apply(mk(0,0,0,0, 1,1, 0,1,1,1), "rl1.z0");
    apply(mk(0,0,0,0, 1,1, 1,0,0,1), "rl1.r0");
    apply(mk(0,0,0,0, 1,1, 0,1,1,1), "rl1.z1");
    // zero load from RUN parks in DONE
    apply(mk(0,0,1,0, 1,1, 0,1,0,0), "rl1.ld0");
    apply(mk(0,0,0,0, 1,1, 0,1,0,0), "rl1.hold");

    // full-range load counts down from 255 to 253
    apply(mk(0,0,1,8'hff, 0,0, 8'hff,0,0,1), "max.ld");
    apply(mk(0,0,0,0, 1,0, 8'hfe,0,0,1), "max.dec1");
    apply(mk(0,0,0,0, 1,0, 8'hfd,0,0,1), "max.dec2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
